// File: rtl/sw_net_pkg.sv
// Shared types and constants for the 2x2 streaming switch stage.
// The switch and its scheduler both take their latency from here.
package sw_net_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  localparam int SW_LAT_DEFAULT = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/sw_net_sched_if.sv
// Control bundle between the upstream stage, the scheduler and the
// downstream stage of the 2x2 switch.
interface sw_net_sched_if #(
  parameter int SW_W = 3
);

  logic            next_in;
  logic [SW_W-1:0] cfg_stride;
  logic            ct;
  logic            itr;
  logic            busy;
  logic            next_out;
  logic            overrun;
  logic            cfg_err;

  modport master (
    output next_in,
    output cfg_stride,
    input  ct,
    input  itr,
    input  busy,
    input  next_out,
    input  overrun,
    input  cfg_err
  );

  modport slave (
    input  next_in,
    input  cfg_stride,
    output ct,
    output itr,
    output busy,
    output next_out,
    output overrun,
    output cfg_err
  );

endinterface

// File: rtl/sw_net_delay.sv
// N-stage 1-bit shift register with asynchronous active-low clear.
// Aligns the frame-start pulse with the switch output latency.
module sw_net_delay #(
  parameter int N = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= '0;
    end else begin
      r_sr <= N'({r_sr, i_d});
    end
  end

  assign o_q = r_sr[N-1];

endmodule

// File: rtl/sw_net_sched.sv
// Frame scheduler for the 2x2 switch: ct select, frame-start pulse,
// one-deep request queue and stride latch per frame.
module sw_net_sched
  import sw_net_pkg::*;
#(
  parameter int FRAME_LEN = 32,
  parameter int LOG_FRAME = clog2(FRAME_LEN),
  parameter int SW_LAT    = SW_LAT_DEFAULT,
  parameter int SW_W      = 3
) (
  input logic           clk,
  input logic           rst_n,
  sw_net_sched_if.slave bus
);

  localparam logic [LOG_FRAME-1:0] LAST = LOG_FRAME'(FRAME_LEN - 1);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [LOG_FRAME-1:0] r_cnt;
  logic [LOG_FRAME-1:0] w_cnt_nxt;
  logic [SW_W-1:0]      r_stride;
  logic [SW_W-1:0]      w_stride_nxt;
  logic                 r_pend;
  logic                 w_pend_nxt;
  logic                 r_ct;
  logic                 w_ct_nxt;
  logic                 r_itr;
  logic                 r_ovr;
  logic                 w_ovr_nxt;
  logic                 r_err;
  logic                 w_err_nxt;
  logic                 w_start;
  logic                 w_last;
  logic                 w_nxo;

  assign w_last = (r_state == ST_RUN) && (r_cnt == LAST);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_stride_nxt = r_stride;
    w_pend_nxt   = r_pend;
    w_ovr_nxt    = r_ovr;
    w_err_nxt    = r_err;
    w_start      = 1'b0;
    w_ct_nxt     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_start = bus.next_in;
      end
      ST_RUN: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_last) begin
          // a fresh request here refills the slot the pending one frees
          w_start    = r_pend | bus.next_in;
          w_pend_nxt = r_pend & bus.next_in;
          if (!w_start) w_state_nxt = ST_IDLE;
        end else if (bus.next_in) begin
          if (r_pend) w_ovr_nxt = 1'b1;
          else        w_pend_nxt = 1'b1;
        end
      end
      default: ;
    endcase
    if (w_start) begin
      w_state_nxt  = ST_RUN;
      w_cnt_nxt    = '0;
      w_stride_nxt = bus.cfg_stride;
      if (int'(bus.cfg_stride) >= LOG_FRAME) w_err_nxt = 1'b1;
    end
    // ct is computed from next-cycle values so it lines up with r_cnt
    if (w_state_nxt == ST_RUN && int'(w_stride_nxt) < LOG_FRAME) begin
      w_ct_nxt = |(w_cnt_nxt & (LOG_FRAME'(1) << w_stride_nxt));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_stride <= '0;
      r_pend   <= 1'b0;
      r_ct     <= 1'b0;
      r_itr    <= 1'b0;
      r_ovr    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_stride <= w_stride_nxt;
      r_pend   <= w_pend_nxt;
      r_ct     <= w_ct_nxt;
      r_itr    <= w_start;
      r_ovr    <= w_ovr_nxt;
      r_err    <= w_err_nxt;
    end
  end

  sw_net_delay #(
    .N(SW_LAT)
  ) u_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (r_itr),
    .o_q  (w_nxo)
  );

  assign bus.ct       = r_ct;
  assign bus.itr      = r_itr;
  assign bus.busy     = (r_state == ST_RUN);
  assign bus.next_out = w_nxo;
  assign bus.overrun  = r_ovr;
  assign bus.cfg_err  = r_err;

endmodule

// File: tb/tb_sw_net_sched.sv
// Bench for sw_net_sched: per-cycle scoreboard of expected ct/itr/busy
// and next_out, fed by table-driven frames and hand-built sequences.
module tb_sw_net_sched;

  localparam int FL  = 32;
  localparam int LF  = 5;
  localparam int LAT = 3;

  typedef struct packed {
    logic ct;
    logic itr;
  } exp_t;

  typedef struct {
    int   stride;
    logic err;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  logic [LAT-1:0] nxo;
  vec_t tbl[8];

  sw_net_sched_if #(.SW_W(3)) bus ();

  sw_net_sched #(
    .FRAME_LEN(FL),
    .LOG_FRAME(LF),
    .SW_LAT   (LAT),
    .SW_W     (3)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    logic eb;
    e  = '0;
    eb = (exp_q.size() > 0);
    chk("busy", bus.busy, eb);
    if (eb) e = exp_q.pop_front();
    chk("ct", bus.ct, e.ct);
    chk("itr", bus.itr, e.itr);
    chk("next_out", bus.next_out, nxo[LAT-1]);
    nxo = {nxo[LAT-2:0], e.itr};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic push_frame(input int s);
    exp_t e;
    for (int w = 0; w < FL; w++) begin
      e.ct  = (s < LF) ? 1'(w >> s) : 1'b0;
      e.itr = (w == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic req(input int s);
    bus.cfg_stride = 3'(s);
    bus.next_in    = 1'b1;
    push_frame(s);
    tick();
    bus.next_in = 1'b0;
  endtask

  task automatic drop_req();
    bus.next_in = 1'b1;
    tick();
    bus.next_in = 1'b0;
  endtask

  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    nxo = '0;
    #1;
    chk("rst_ct", bus.ct, 0);
    chk("rst_itr", bus.itr, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ovr", bus.overrun, 0);
    chk("rst_err", bus.cfg_err, 0);
    chk("rst_nxo", bus.next_out, 0);
    run(2);
    rst_n = 1'b1;
    run(2);
  endtask

  initial begin
    tbl[0] = '{0, 1'b0};
    tbl[1] = '{1, 1'b0};
    tbl[2] = '{2, 1'b0};
    tbl[3] = '{3, 1'b0};
    tbl[4] = '{4, 1'b0};
    tbl[5] = '{5, 1'b1};
    tbl[6] = '{6, 1'b1};
    tbl[7] = '{7, 1'b1};
    bus.next_in    = 1'b0;
    bus.cfg_stride = '0;
    nxo            = '0;
    #1;
    chk("init_ct", bus.ct, 0);
    chk("init_busy", bus.busy, 0);
    chk("init_nxo", bus.next_out, 0);
    chk("init_ovr", bus.overrun, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // basic frame, request at cycle 10
    while (cyc < 10) tick();
    req(0);
    run(36);
    chk("t1_drain", exp_q.size(), 0);

    // stride table; cfg_stride moves mid-frame and must be ignored
    for (int i = 0; i < 8; i++) begin
      do_reset();
      req(tbl[i].stride);
      bus.cfg_stride = ~3'(tbl[i].stride);
      run(36);
      chk("tbl_err", bus.cfg_err, tbl[i].err);
      chk("tbl_drain", exp_q.size(), 0);
    end

    // pending at cnt 5, overrun at cnt 20
    do_reset();
    req(0);
    run(5);
    req(2);
    chk("t3_no_ovr", bus.overrun, 0);
    run(14);
    drop_req();
    chk("t3_ovr", bus.overrun, 1);
    run(50);
    chk("t3_drain", exp_q.size(), 0);
    chk("t3_ovr_sticky", bus.overrun, 1);

    // pending plus new request at cnt 31: three frames, no overrun
    do_reset();
    req(0);
    run(5);
    req(3);
    run(25);
    req(3);
    chk("t3b_no_ovr", bus.overrun, 0);
    run(70);
    chk("t3b_drain", exp_q.size(), 0);
    chk("t3b_ovr", bus.overrun, 0);

    // request exactly at cnt 31 with new stride
    do_reset();
    req(2);
    run(31);
    req(1);
    chk("t4_no_ovr", bus.overrun, 0);
    run(40);
    chk("t4_drain", exp_q.size(), 0);
    chk("t4_ovr", bus.overrun, 0);

    // reset mid-frame with pending and overrun set
    do_reset();
    req(0);
    run(5);
    req(0);
    run(1);
    drop_req();
    chk("t6_ovr_set", bus.overrun, 1);
    run(4);
    do_reset();
    run(10);
    req(0);
    run(40);
    chk("t6_drain", exp_q.size(), 0);
    chk("t6_ovr", bus.overrun, 0);

    // reset while the next_out pulse is still in flight
    req(0);
    run(1);
    do_reset();
    run(8);
    chk("t6b_idle", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
